dot_product_engine: RTL

- Parametrised hardwired successor to the microcoded matrix core's inner loop.
- Computes one element C = sum over k of A[k]*B[k] and writes it back to data memory.
- Fetches A and B from DRAM with independent strides, and accumulates at full width.
- Talks to the shared DRAM through a request/acknowledge port, so several engines can sit behind one arbiter.

---
 rtl/dot_engine_pkg.sv | 30 +++
 rtl/dot_product_engine_mac_acc.sv | 29 ++
 rtl/dot_product_engine.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dot_engine_pkg.sv
// Shared types and helpers for the dot-product engine.
// Holds the FSM state encoding, saturation-mode constants and the result narrowing function.
package dot_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_MAC,
        ST_WR,
        ST_DONE
    } state_t;

    localparam bit SAT_OFF = 1'b0;
    localparam bit SAT_ON  = 1'b1;

    // Narrow a full-width sum to data_w bits: clamp or drop the high bits.
    function automatic logic [63:0] sat_trunc(
        input logic [63:0] acc,
        input int unsigned data_w,
        input bit          sat
    );
        logic [63:0] max_v;
        max_v = (64'd1 << data_w) - 64'd1;
        if (sat == SAT_ON)
            return (acc > max_v) ? max_v : acc;
        return acc & max_v;
    endfunction

endpackage

// File: rtl/dot_product_engine_mac_acc.sv
// Full-width multiply-accumulate register for the dot-product engine.
// Ports: clk/rst, clr (zero acc), en (acc += a*b), a/b operands, acc and acc_next (acc + a*b).
module mac_acc #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  acc_next
);

    // Unsigned product, wraps modulo 2^ACC_W.
    assign acc_next = acc + ACC_W'(a) * ACC_W'(b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc_next;
    end

endmodule

// File: rtl/dot_product_engine.sv
// Hardwired dot-product engine: reads A[k], B[k] over a req/ack DRAM port,
// accumulates sum A[k]*B[k] and writes the narrowed result to base_c.
// Ports: i_clk/i_rst, i_start + job config (bases, strides, len), DRAM
// port (o_dram_addr/read/write/out, i_dram_in/ack), o_busy, o_done, o_acc.
module dot_product_engine
    import dot_engine_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 24,
    parameter bit SAT    = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_a,
    input  logic [ADDR_W-1:0] i_base_b,
    input  logic [ADDR_W-1:0] i_base_c,
    input  logic [ADDR_W-1:0] i_stride_a,
    input  logic [ADDR_W-1:0] i_stride_b,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [DATA_W-1:0] i_dram_in,
    input  logic              i_dram_ack,
    output logic [ADDR_W-1:0] o_dram_addr,
    output logic              o_dram_read,
    output logic              o_dram_write,
    output logic [DATA_W-1:0] o_dram_out,
    output logic              o_busy,
    output logic              o_done,
    output logic [ACC_W-1:0]  o_acc
);

    state_t            state;
    logic [ADDR_W-1:0] ptr_a;
    logic [ADDR_W-1:0] ptr_b;
    logic [ADDR_W-1:0] stride_a;
    logic [ADDR_W-1:0] stride_b;
    logic [ADDR_W-1:0] base_c;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  k;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [ACC_W-1:0]  acc_next;
    logic              acc_clr;
    logic              acc_en;
    logic              last;

    assign acc_clr = (state == ST_IDLE) && i_start;
    assign acc_en  = (state == ST_MAC);
    assign last    = (k == len_r - LEN_W'(1));

    mac_acc #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (i_clk),
        .rst     (i_rst),
        .clr     (acc_clr),
        .en      (acc_en),
        .a       (op_a),
        .b       (op_b),
        .acc     (o_acc),
        .acc_next(acc_next)
    );

    // Outputs are registered: each transition loads the request
    // that the next state presents.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            ptr_a        <= '0;
            ptr_b        <= '0;
            stride_a     <= '0;
            stride_b     <= '0;
            base_c       <= '0;
            len_r        <= '0;
            k            <= '0;
            op_a         <= '0;
            op_b         <= '0;
            o_dram_addr  <= '0;
            o_dram_read  <= 1'b0;
            o_dram_write <= 1'b0;
            o_dram_out   <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        ptr_a    <= i_base_a;
                        ptr_b    <= i_base_b;
                        stride_a <= i_stride_a;
                        stride_b <= i_stride_b;
                        base_c   <= i_base_c;
                        len_r    <= i_len;
                        k        <= '0;
                        o_busy   <= 1'b1;
                        if (i_len == '0) begin
                            state        <= ST_WR;
                            o_dram_write <= 1'b1;
                            o_dram_addr  <= i_base_c;
                            o_dram_out   <= '0;
                        end else begin
                            state       <= ST_RD_A;
                            o_dram_read <= 1'b1;
                            o_dram_addr <= i_base_a;
                        end
                    end
                end
                ST_RD_A: begin
                    if (i_dram_ack) begin
                        op_a        <= i_dram_in;
                        o_dram_addr <= ptr_b;
                        state       <= ST_RD_B;
                    end
                end
                ST_RD_B: begin
                    if (i_dram_ack) begin
                        op_b        <= i_dram_in;
                        o_dram_read <= 1'b0;
                        o_dram_addr <= '0;
                        state       <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    ptr_a <= ptr_a + stride_a;
                    ptr_b <= ptr_b + stride_b;
                    k     <= k + LEN_W'(1);
                    if (last) begin
                        state        <= ST_WR;
                        o_dram_write <= 1'b1;
                        o_dram_addr  <= base_c;
                        o_dram_out   <= DATA_W'(sat_trunc(
                            64'(acc_next), DATA_W, SAT));
                    end else begin
                        state       <= ST_RD_A;
                        o_dram_read <= 1'b1;
                        o_dram_addr <= ptr_a + stride_a;
                    end
                end
                ST_WR: begin
                    if (i_dram_ack) begin
                        o_dram_write <= 1'b0;
                        o_dram_addr  <= '0;
                        o_dram_out   <= '0;
                        o_done       <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
